// File: rtl/button_event.sv
// button_event: turns a debounced button level into press / release /
// long-hold / auto-repeat pulses plus a held level. All outputs are registered.
// Build option: define BUTTON_EVENT_AUTO_REPEAT_EN to enable o_repeat pulses
// while long-held; undefined, o_repeat stays 0 and the counter idles in LONG.
module button_event #(
    parameter int LONG_CYCLES   = 12_000_000,
    parameter int REPEAT_CYCLES = 2_400_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);

    // Counter must hold terminal values up to max(LONG, REPEAT) - 1.
    localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             r_level_q;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;
    logic             rise, fall;

    assign rise = i_level & ~r_level_q;
    assign fall = ~i_level & r_level_q;

    // Next-state, counter and output-pulse decode; release beats any terminal count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            PRESS: begin
                if (fall) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (i_level) begin
                    if (cnt_q == LONG_TC) begin
                        state_d = LONG;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LONG: begin
                if (fall) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
                    if (i_level) begin
                        if (cnt_q == REP_TC) begin
                            cnt_d    = '0;
                            repeat_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d != IDLE);
    end

    // State, counter, level history and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            r_level_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_level_q <= i_level;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_long    = long_q;
    assign o_repeat  = repeat_q;
    assign o_held    = held_q;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: a run-length reference model of the input level
// predicts every output each cycle; directed scenarios pin event cycle numbers.
module tb_button_event;

    localparam int L = 8;
    localparam int R = 4;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic lvl;
    logic o_press, o_release, o_long, o_repeat, o_held;

    button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
        .i_clk(clk), .i_rst(rst), .i_level(lvl),
        .o_press(o_press), .o_release(o_release), .o_long(o_long),
        .o_repeat(o_repeat), .o_held(o_held)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: m_n = length of the current run of 1s sampled since reset,
    // m_c = latest sample, m_p = sample before it.
    int   m_n;
    logic m_c, m_p;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n <= 0;
            m_c <= 1'b0;
            m_p <= 1'b0;
        end else begin
            m_p <= m_c;
            m_c <= lvl;
            m_n <= lvl ? m_n + 1 : 0;
        end
    end

    int checks = 0;
    int errors = 0;
    int n_press = 0, n_release = 0, n_long = 0, n_held = 0;
    int last_press = -1, last_release = -1, last_long = -1;
    int rep_q[$];
    logic [4:0] e_v, a_v;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drv(input logic v, input int n);
        repeat (n) begin
            lvl = v;
            @(posedge clk);
            #3;
        end
    endtask

    int base, s_long, s_held, s_rel, s_press, s_rep, len;

    initial begin
        rst = 1'b1;
        lvl = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("reset_outputs", int'({o_press, o_release, o_long, o_repeat, o_held}), 0);
        rst = 1'b0;

        fork
            forever begin
                @(negedge clk);
                e_v[4] = m_c && (m_n == 1);
                e_v[3] = !m_c && m_p;
                e_v[2] = m_c && (m_n == L + 1);
                e_v[1] = REP_ON && m_c && (m_n > L + 1) && (((m_n - L - 1) % R) == 0);
                e_v[0] = m_c;
                a_v = {o_press, o_release, o_long, o_repeat, o_held};
                checks++;
                if (a_v !== e_v) begin
                    errors++;
                    $display("FAIL cycle_outputs press/rel/long/rep/held got %b want %b (cycle %0d)", a_v, e_v, cyc);
                end
                checks++;
                if ($countones(a_v[4:1]) > 1) begin
                    errors++;
                    $display("FAIL onehot_pulses got %b want at most one (cycle %0d)", a_v[4:1], cyc);
                end
                if (o_press)   begin n_press++;   last_press   = cyc; end
                if (o_release) begin n_release++; last_release = cyc; end
                if (o_long)    begin n_long++;    last_long    = cyc; end
                if (o_repeat)  rep_q.push_back(cyc);
                if (o_held)    n_held++;
            end
        join_none

        drv(1'b0, 5);

        // Short press: 3 cycles high.
        s_long = n_long; s_held = n_held; s_press = n_press;
        base = cyc;
        drv(1'b1, 3);
        drv(1'b0, 8);
        chk("short_press_cyc", last_press, base + 1);
        chk("short_press_cnt", n_press - s_press, 1);
        chk("short_release_cyc", last_release, base + 4);
        chk("short_no_long", n_long - s_long, 0);
        chk("short_held_cycles", n_held - s_held, 3);

        // Long press: 30 cycles high.
        s_rep = rep_q.size();
        base = cyc;
        drv(1'b1, 30);
        drv(1'b0, 8);
        chk("long_press_cyc", last_press, base + 1);
        chk("long_long_cyc", last_long, base + 9);
        chk("long_release_cyc", last_release, base + 31);
        chk("long_repeat_cnt", rep_q.size() - s_rep, REP_ON ? 5 : 0);
        if (REP_ON && rep_q.size() - s_rep == 5) begin
            chk("long_repeat_first", rep_q[s_rep], base + 13);
            chk("long_repeat_last", rep_q[s_rep + 4], base + 29);
        end

        // Boundary: release coincides with the long terminal count.
        s_long = n_long;
        base = cyc;
        drv(1'b1, 8);
        drv(1'b0, 8);
        chk("bound_press_cyc", last_press, base + 1);
        chk("bound_release_cyc", last_release, base + 9);
        chk("bound_no_long", n_long - s_long, 0);

        // Reset in the middle of a hold.
        drv(1'b1, 5);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", int'({o_press, o_release, o_long, o_repeat, o_held}), 0);
        @(posedge clk); #3;
        @(posedge clk); #3;
        s_rel = n_release;
        rst = 1'b0;
        base = cyc;
        drv(1'b1, 4);
        chk("midrst_press_cyc", last_press, base + 1);
        chk("midrst_no_release", n_release - s_rel, 0);
        drv(1'b0, 6);

        // Randomized runs with occasional reset pulses.
        repeat (150) begin
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 12);
            drv(1'(($urandom_range(0, 1))), len);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                @(posedge clk); #3;
                rst = 1'b0;
            end
        end
        drv(1'b0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 The block SHALL have parameter LONG_CYCLES, default 12_000_000: clock cycles from o_press to o_long while held.
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 2_400_000: clock cycles between successive o_repeat pulses.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port i_level, input, 1 bit: debounced, i_clk-synchronous button level (1 = pressed).
REQ-006 The block SHALL have port o_press, output, 1 bit: one-cycle pulse on press.
REQ-007 The block SHALL have port o_release, output, 1 bit: one-cycle pulse on release.
REQ-008 The block SHALL have port o_long, output, 1 bit: one-cycle pulse when the long-hold threshold is reached.
REQ-009 The block SHALL have port o_repeat, output, 1 bit: one-cycle auto-repeat pulse while long-held.
REQ-010 The block SHALL have port o_held, output, 1 bit: level, high while the FSM is in PRESS or LONG.

Function
REQ-011 The block SHALL register i_level into r_level every cycle and detect rise as i_level=1 with r_level=0, and fall as i_level=0 with r_level=1.
REQ-012 The FSM SHALL have states IDLE, PRESS and LONG, with all outputs registered.
REQ-013 IDLE on rise SHALL go to PRESS, clear the counter, and assert o_press for the next cycle only.
REQ-014 In PRESS, the counter SHALL increment each cycle while i_level=1; o_long SHALL rise exactly LONG_CYCLES cycles after o_press rose, for one cycle, with state to LONG and the counter cleared.
REQ-015 Fall in PRESS or LONG SHALL go to IDLE, clear the counter, and assert o_release for one cycle, with latency 1 cycle (same as o_press).
REQ-016 If fall coincides with the PRESS terminal count, release SHALL win: o_release pulses, o_long does not, and state goes to IDLE.
REQ-017 If fall coincides with a repeat terminal count, o_release SHALL pulse and o_repeat SHALL NOT.
REQ-018 o_held SHALL be 1 in the cycle o_press is high through the cycle before o_release is high.
REQ-019 The counter width SHALL be $clog2 of max(LONG_CYCLES, REPEAT_CYCLES), and it SHALL never wrap; it is cleared on every state change.
REQ-020 At most one of o_press, o_release, o_long, o_repeat SHALL be high in any cycle.
REQ-021 Legal parameters SHALL be LONG_CYCLES >= 2 and REPEAT_CYCLES >= 1; other values are unsupported.

Reset
REQ-022 Assertion of i_rst at any time, including mid-press, SHALL immediately force state IDLE, counter 0, r_level 0, and all outputs 0.
REQ-023 If i_level=1 when i_rst deasserts, the first clock edge SHALL see a rise and o_press SHALL pulse; no o_release SHALL be generated for a press interrupted by reset.

Configuration
REQ-024 Macro BUTTON_EVENT_AUTO_REPEAT_EN defined: in LONG, the counter SHALL count while held, with o_repeat pulsing REPEAT_CYCLES after o_long rose and every REPEAT_CYCLES thereafter.
REQ-025 Macro BUTTON_EVENT_AUTO_REPEAT_EN undefined: o_repeat SHALL be constant 0, the counter SHALL hold at 0 in LONG, and REPEAT_CYCLES SHALL be ignored; all other behaviour SHALL be identical.

Verification (LONG_CYCLES=8, REPEAT_CYCLES=4)
REQ-026 Short press: i_level high 3 cycles from cycle 10 -> o_press at cycle 11, o_release at cycle 14, no o_long, o_held high cycles 11-13.
REQ-027 Long press with macro defined: i_level high from cycle 10 for 30 cycles -> o_press at 11, o_long at 19, o_repeat at 23/27/31/35/39, o_release at 41.
REQ-028 Same stimulus with macro undefined -> o_press at 11, o_long at 19, no o_repeat, o_release at 41.
REQ-029 Boundary: i_level high exactly 8 cycles from cycle 10 -> o_press at 11, o_release at 19, o_long never asserted.
REQ-030 Reset mid-hold: i_rst pulsed at cycle 15 during a press while i_level stays high -> outputs 0 at once, fresh o_press one cycle after the first edge post-deassert, no o_release.
